// File: rtl/teclado_digitos.sv
// teclado_digitos: 4x4 matrix keypad front-end for the lock.
//
// Scans the keypad one column at a time, debounces each press and release,
// encodes the key into a 4-bit digit and shifts it into a 20-digit buffer.
// The buffer is cleared after '*' / '#' and after an inactivity timeout.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   lin_matrix    keypad rows, active-low, externally pulled up
//   col_matrix    keypad column drive, active-low, one-hot-zero
//   digitos_value digit buffer, .digits[0] is the newest, 0xF means empty
//   digitos_valid one-cycle pulse when a new digit enters the buffer

package teclado_digitos_pkg;
    typedef struct packed {
        logic [19:0][3:0] digits;
    } senhaPac_t;
endpackage

module teclado_digitos
    import teclado_digitos_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] lin_matrix,
    output logic [3:0] col_matrix,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid
);

    localparam int unsigned SW = $clog2(SCAN_CYCLES + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    // Rows seen through the synchronizer lag the column drive by two cycles.
    localparam logic [SW-1:0] SETTLE    = SW'(2);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StScan, StDebounce, StWaitRelease} state_e;

    state_e          state;
    logic [3:0]      lin_s1, lin_s2;
    logic [SW-1:0]   scan_cnt;
    logic [DW-1:0]   deb_cnt;
    logic [TW-1:0]   idle_cnt;
    logic [3:0]      lat_rows;
    logic [3:0]      lat_code;
    logic            lat_mapped;
    logic            clear_pending;

    logic            row_ok;
    logic [1:0]      row_idx;
    logic [1:0]      col_idx;
    logic            key_mapped;
    logic [3:0]      key_code;
    logic            accept;
    logic            buffer_empty;

    // Exactly one low row in the driven column is a press; anything else is no key.
    always_comb begin
        row_ok  = 1'b1;
        row_idx = 2'd0;
        case (lin_s2)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (col_matrix)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            default: col_idx = 2'd3;
        endcase
    end

    // Rows 0..2 hold 1..9 in columns 0..2; row 3 holds '*', 0, '#'; column 3 is letters.
    always_comb begin
        key_mapped = 1'b0;
        key_code   = 4'h0;
        if (row_idx != 2'd3) begin
            if (col_idx != 2'd3) begin
                key_mapped = 1'b1;
                key_code   = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
            end
        end else begin
            case (col_idx)
                2'd0:    begin key_mapped = 1'b1; key_code = 4'hA; end
                2'd1:    begin key_mapped = 1'b1; key_code = 4'h0; end
                2'd2:    begin key_mapped = 1'b1; key_code = 4'hB; end
                default: begin key_mapped = 1'b0; key_code = 4'h0; end
            endcase
        end
    end

    always_comb begin
        accept       = (state == StDebounce) && (lin_s2 == lat_rows) &&
                       (deb_cnt == DEB_LAST) && lat_mapped;
        buffer_empty = (digitos_value == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lin_s1        <= 4'hF;
            lin_s2        <= 4'hF;
            state         <= StScan;
            col_matrix    <= 4'b1110;
            scan_cnt      <= '0;
            deb_cnt       <= '0;
            idle_cnt      <= '0;
            lat_rows      <= 4'hF;
            lat_code      <= 4'h0;
            lat_mapped    <= 1'b0;
            clear_pending <= 1'b0;
            digitos_value <= '1;
            digitos_valid <= 1'b0;
        end else begin
            lin_s1        <= lin_matrix;
            lin_s2        <= lin_s1;
            digitos_valid <= 1'b0;

            // Buffer and inactivity timeout; acceptance takes priority over timeout.
            if (accept) begin
                digitos_value.digits <= {digitos_value.digits[18:0], lat_code};
                digitos_valid        <= 1'b1;
                clear_pending        <= (lat_code == 4'hA) || (lat_code == 4'hB);
                idle_cnt             <= '0;
            end else if (clear_pending) begin
                digitos_value <= '1;
                clear_pending <= 1'b0;
                idle_cnt      <= '0;
            end else if (!buffer_empty) begin
                if (idle_cnt == TO_LAST) begin
                    digitos_value <= '1;
                    idle_cnt      <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                StScan: begin
                    if (scan_cnt >= SETTLE && row_ok) begin
                        lat_rows   <= lin_s2;
                        lat_code   <= key_code;
                        lat_mapped <= key_mapped;
                        deb_cnt    <= '0;
                        state      <= StDebounce;
                    end else if (scan_cnt == SCAN_LAST) begin
                        scan_cnt   <= '0;
                        col_matrix <= {col_matrix[2:0], col_matrix[3]};
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                StDebounce: begin
                    if (lin_s2 != lat_rows) begin
                        scan_cnt <= '0;
                        state    <= StScan;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        state   <= StWaitRelease;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                StWaitRelease: begin
                    if (lin_s2 == 4'hF) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt  <= '0;
                            scan_cnt <= '0;
                            state    <= StScan;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_cnt <= '0;
                    end
                end
                default: state <= StScan;
            endcase
        end
    end

endmodule

// File: tb/tb_teclado_digitos.sv
// Bench for teclado_digitos: a keypad model drives the rows from the pressed-key
// set and the column drive; a digit-buffer model predicts every pulse and value.

module tb_teclado_digitos;
    import teclado_digitos_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  lin_matrix;
    logic [3:0]  col_matrix;
    senhaPac_t   digitos_value;
    logic        digitos_valid;

    logic [15:0] pressed = '0;     // bit r*4+c set while key (c, r) is held
    logic [79:0] model = '1;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pulse_cnt = 0;
    logic [79:0] last_val = '1;
    logic [79:0] post_val = '1;
    logic        valid_d = 1'b0;
    string       keymap[4] = '{"123A", "456B", "789C", "*0#D"};

    teclado_digitos #(
        .SCAN_CYCLES    (4),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lin_matrix   (lin_matrix),
        .col_matrix   (col_matrix),
        .digitos_value(digitos_value),
        .digitos_valid(digitos_valid)
    );

    always #5 clk = ~clk;

    // Passive keypad: a row is pulled low by any held key in a driven column.
    always_comb begin
        lin_matrix = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[r*4+c] && !col_matrix[c]) lin_matrix[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (digitos_valid) begin
            pulse_cnt = pulse_cnt + 1;
            last_val  = digitos_value;
        end
        if (valid_d) post_val = digitos_value;
        valid_d = digitos_valid;
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic key_lookup(input int c, input int r, output bit mapped, output logic [3:0] code);
        byte ch;
        string row;
        row    = keymap[r];
        ch     = row[c];
        mapped = 1'b1;
        code   = 4'h0;
        if (ch >= "0" && ch <= "9") code = 4'(ch - "0");
        else if (ch == "*") code = 4'hA;
        else if (ch == "#") code = 4'hB;
        else mapped = 1'b0;
    endtask

    task automatic do_press(input int c, input int r, input int hold);
        int         p0;
        bit         mapped;
        logic [3:0] code;
        p0      = pulse_cnt;
        pressed = 16'(1) << (r * 4 + c);
        repeat (hold) @(posedge clk);
        pressed = '0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        key_lookup(c, r, mapped, code);
        if (mapped) begin
            model = {model[75:0], code};
            check("pulse_count", 80'(pulse_cnt - p0), 80'd1);
            check("value_at_pulse", last_val, model);
            if (code == 4'hA || code == 4'hB) model = '1;
            check("value_after_pulse", post_val, model);
        end else begin
            check("no_pulse_unmapped", 80'(pulse_cnt - p0), 80'd0);
        end
        check("buffer", digitos_value, model);
    endtask

    initial begin
        int         p0;
        int         bad;
        int         k;
        logic [3:0] seen;
        logic [3:0] prev;

        // Reset state and idle scanning
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_col", 80'(col_matrix), 80'(4'b1110));
        check("reset_value", digitos_value, '1);
        check("reset_valid", 80'(digitos_valid), 80'd0);
        rst  = 1'b0;
        p0   = pulse_cnt;
        bad  = 0;
        seen = '0;
        prev = col_matrix;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            seen = seen | ~col_matrix;
            if (col_matrix != prev && col_matrix != {prev[2:0], prev[3]}) bad++;
            prev = col_matrix;
        end
        check("idle_no_pulse", 80'(pulse_cnt - p0), 80'd0);
        check("idle_value", digitos_value, '1);
        check("idle_col_order", 80'(bad), 80'd0);
        check("idle_cols_seen", 80'(seen), 80'(4'b1111));

        // Key 5, then 1 2 3 #
        do_press(1, 1, 30);
        do_press(0, 0, 35);
        do_press(1, 0, 35);
        do_press(2, 0, 35);
        do_press(2, 3, 35);

        // Bouncing row 2 of column 0, then the same key held steadily
        p0 = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            pressed[8] = ~pressed[8];
            repeat (2) @(posedge clk);
        end
        pressed = '0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("bounce_no_pulse", 80'(pulse_cnt - p0), 80'd0);
        check("bounce_buffer", digitos_value, model);
        do_press(0, 2, 35);

        // Key 4 then inactivity timeout
        do_press(0, 1, 35);
        p0 = pulse_cnt;
        repeat (200) @(posedge clk);
        @(negedge clk);
        model = '1;
        check("timeout_buffer", digitos_value, model);
        check("timeout_no_pulse", 80'(pulse_cnt - p0), 80'd0);

        // Letter D and a two-row press leave a non-empty buffer untouched
        do_press(0, 0, 35);
        do_press(3, 3, 35);
        p0      = pulse_cnt;
        pressed = 16'h0011;
        repeat (35) @(posedge clk);
        pressed = '0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("two_rows_no_pulse", 80'(pulse_cnt - p0), 80'd0);
        check("two_rows_buffer", digitos_value, model);

        // Key 9, then reset while the key is still held
        p0      = pulse_cnt;
        pressed = 16'(1) << 10;
        k       = 0;
        while (pulse_cnt == p0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        model = {model[75:0], 4'h9};
        check("key9_pulse", 80'(pulse_cnt - p0), 80'd1);
        check("key9_value", last_val, model);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_col", 80'(col_matrix), 80'(4'b1110));
        check("midrst_value", digitos_value, '1);
        check("midrst_valid", 80'(digitos_valid), 80'd0);
        pressed = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        model = '1;
        do_press(1, 3, 35);

        // Overflow: more than 20 digits without a terminator
        for (int i = 0; i < 22; i++)
            do_press(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     int'($urandom_range(30, 40)));

        // Random keys with occasional long idle gaps
        for (int i = 0; i < 30; i++) begin
            do_press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(30, 40)));
            if ($urandom_range(0, 7) == 0) begin
                p0 = pulse_cnt;
                repeat (210) @(posedge clk);
                @(negedge clk);
                model = '1;
                check("rand_timeout", digitos_value, model);
                check("rand_timeout_no_pulse", 80'(pulse_cnt - p0), 80'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
